// File: rtl/select_decoder_seq.sv
// select_decoder_seq: registered one-hot select decoder with valid/ready handshake.
// A SEL_W-bit index becomes a 2**SEL_W-bit one-hot strobe held for HOLD cycles,
// followed by at least one all-zero cycle before the next strobe.
// Optional sweep mode (compile with SELDEC_SWEEP_EN) walks every output in turn,
// HOLD cycles each with no gap, and pulses sweep_done_o when the walk finishes.
// Without the macro the sweep logic is not built, sweep_start_i is ignored and
// sweep_done_o is tied low; the port list is the same in both builds.
module select_decoder_seq #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned HOLD  = 1
) (
    input  logic                  clock_i,
    input  logic                  clear_i,
    input  logic                  sel_valid_i,
    output logic                  sel_ready_o,
    input  logic [SEL_W-1:0]      sel_in_i,
    input  logic                  sweep_start_i,
    output logic [(2**SEL_W)-1:0] dec_out_o,
    output logic                  dec_valid_o,
    output logic                  busy_o,
    output logic                  sweep_done_o
);

    localparam int unsigned OUT_W = 2 ** SEL_W;
    // One counter bit minimum so HOLD = 1 still has a legal register.
    localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(HOLD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StSweep
    } state_e;

    state_e           state_q;
    logic [OUT_W-1:0] dec_out_q;
    logic             dec_valid_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sweep_start_eff;

`ifdef SELDEC_SWEEP_EN
    localparam logic [SEL_W-1:0] IdxLast = SEL_W'(OUT_W - 1);

    logic [SEL_W-1:0] index_q;
    logic             sweep_done_q;

    assign sweep_start_eff = sweep_start_i;
    assign sweep_done_o    = sweep_done_q;
`else
    logic unused_sweep_start;

    assign unused_sweep_start = sweep_start_i;
    assign sweep_start_eff    = 1'b0;
    assign sweep_done_o       = 1'b0;
`endif

    // A pending sweep start takes priority, so a simultaneous request is refused.
    assign sel_ready_o = (state_q == StIdle) && !sweep_start_eff;

    // Control FSM with registered strobe, status and counters.
    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            state_q     <= StIdle;
            dec_out_q   <= '0;
            dec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef SELDEC_SWEEP_EN
            index_q      <= '0;
            sweep_done_q <= 1'b0;
`endif
        end else begin
`ifdef SELDEC_SWEEP_EN
            sweep_done_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
`ifdef SELDEC_SWEEP_EN
                    if (sweep_start_eff) begin
                        state_q     <= StSweep;
                        index_q     <= '0;
                        dec_out_q   <= OUT_W'(1);
                        dec_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= CntLoad;
                    end else
`endif
                    if (sel_valid_i) begin
                        state_q     <= StHold;
                        dec_out_q   <= OUT_W'(1) << sel_in_i;
                        dec_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= CntLoad;
                    end
                end
                StHold: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q     <= StIdle;
                        dec_out_q   <= '0;
                        dec_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
`ifdef SELDEC_SWEEP_EN
                StSweep: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (index_q != IdxLast) begin
                        // Move straight to the next output, no idle gap.
                        dec_out_q <= {dec_out_q[OUT_W-2:0], 1'b0};
                        index_q   <= index_q + SEL_W'(1);
                        cnt_q     <= CntLoad;
                    end else begin
                        state_q      <= StIdle;
                        dec_out_q    <= '0;
                        dec_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        index_q      <= '0;
                        sweep_done_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= StIdle;
                    dec_out_q   <= '0;
                    dec_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign dec_out_o   = dec_out_q;
    assign dec_valid_o = dec_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_select_decoder_seq.sv
// Self-checking bench for select_decoder_seq. Three instances: SEL_W=4/HOLD=2,
// SEL_W=4/HOLD=1 and SEL_W=3/HOLD=2 (sweep). Inputs change #1 after a rising
// edge, outputs are sampled on the falling edge.
module tb_select_decoder_seq;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;

    // Instance A: SEL_W=4, HOLD=2
    logic        a_valid, a_ready, a_sweep, a_dv, a_busy, a_done;
    logic [3:0]  a_sel;
    logic [15:0] a_dec;
    // Instance B: SEL_W=4, HOLD=1
    logic        b_valid, b_ready, b_sweep, b_dv, b_busy, b_done;
    logic [3:0]  b_sel;
    logic [15:0] b_dec;
    // Instance C: SEL_W=3, HOLD=2
    logic        c_valid, c_ready, c_sweep, c_dv, c_busy, c_done;
    logic [2:0]  c_sel;
    logic [7:0]  c_dec;

    select_decoder_seq #(.SEL_W(4), .HOLD(2)) u_a (
        .clock_i(clk), .clear_i(clear), .sel_valid_i(a_valid), .sel_ready_o(a_ready),
        .sel_in_i(a_sel), .sweep_start_i(a_sweep), .dec_out_o(a_dec),
        .dec_valid_o(a_dv), .busy_o(a_busy), .sweep_done_o(a_done)
    );
    select_decoder_seq #(.SEL_W(4), .HOLD(1)) u_b (
        .clock_i(clk), .clear_i(clear), .sel_valid_i(b_valid), .sel_ready_o(b_ready),
        .sel_in_i(b_sel), .sweep_start_i(b_sweep), .dec_out_o(b_dec),
        .dec_valid_o(b_dv), .busy_o(b_busy), .sweep_done_o(b_done)
    );
    select_decoder_seq #(.SEL_W(3), .HOLD(2)) u_c (
        .clock_i(clk), .clear_i(clear), .sel_valid_i(c_valid), .sel_ready_o(c_ready),
        .sel_in_i(c_sel), .sweep_start_i(c_sweep), .dec_out_o(c_dec),
        .dec_valid_o(c_dv), .busy_o(c_busy), .sweep_done_o(c_done)
    );

    task automatic test_reset_values();
        // clear is high here
        tot++; if (a_dec !== 16'h0000) begin bad++; $display("FAIL rst_a_dec got=%h exp=0000", a_dec); end
        tot++; if ({a_dv, a_busy, a_done} !== 3'b000) begin bad++; $display("FAIL rst_a_flags got=%b exp=000", {a_dv, a_busy, a_done}); end
        tot++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_a_ready got=%b exp=1", a_ready); end
        tot++; if (b_dec !== 16'h0000) begin bad++; $display("FAIL rst_b_dec got=%h exp=0000", b_dec); end
        tot++; if ({c_dec, c_dv, c_busy, c_done} !== 11'd0) begin bad++; $display("FAIL rst_c got=%h exp=0", {c_dec, c_dv, c_busy, c_done}); end
    endtask

    task automatic test_single();
        @(negedge clk); a_valid = 1'b1; a_sel = 4'hA;
        tot++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_ready_idle got=%b exp=1", a_ready); end
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        tot++; if (a_dec !== 16'h0400) begin bad++; $display("FAIL single_c1 got=%h exp=0400", a_dec); end
        tot++; if ({a_dv, a_busy, a_ready} !== 3'b110) begin bad++; $display("FAIL single_flags1 got=%b exp=110", {a_dv, a_busy, a_ready}); end
        @(posedge clk); @(negedge clk);
        tot++; if (a_dec !== 16'h0400) begin bad++; $display("FAIL single_c2 got=%h exp=0400", a_dec); end
        tot++; if (a_ready !== 1'b0) begin bad++; $display("FAIL single_ready2 got=%b exp=0", a_ready); end
        @(posedge clk); @(negedge clk);
        tot++; if (a_dec !== 16'h0000) begin bad++; $display("FAIL single_c3 got=%h exp=0000", a_dec); end
        tot++; if ({a_dv, a_busy, a_ready} !== 3'b001) begin bad++; $display("FAIL single_flags3 got=%b exp=001", {a_dv, a_busy, a_ready}); end
    endtask

    task automatic test_exhaustive();
        logic [15:0] exp;
        @(negedge clk); b_valid = 1'b1; b_sel = 4'd0;
        for (int i = 0; i < 16; i++) begin
            exp = 16'd1 << i;
            @(posedge clk); #1 b_sel = 4'(i + 1);
            @(negedge clk);
            tot++; if (b_dec !== exp) begin bad++; $display("FAIL exh_strobe idx=%0d got=%h exp=%h", i, b_dec, exp); end
            tot++; if ($countones(b_dec) != 1 || b_dv !== 1'b1) begin bad++; $display("FAIL exh_onehot idx=%0d got=%h dv=%b exp=one-hot dv=1", i, b_dec, b_dv); end
            @(posedge clk); @(negedge clk);
            tot++; if (b_dec !== 16'h0000 || b_ready !== 1'b1) begin bad++; $display("FAIL exh_gap idx=%0d got=%h ready=%b exp=0000 ready=1", i, b_dec, b_ready); end
        end
        b_valid = 1'b0;
    endtask

    task automatic test_held();
        @(negedge clk); a_valid = 1'b1; a_sel = 4'd3;
        @(posedge clk); #1 a_sel = 4'd9;
        @(negedge clk);
        tot++; if (a_dec !== 16'h0008) begin bad++; $display("FAIL held_c1 got=%h exp=0008", a_dec); end
        @(posedge clk); @(negedge clk);
        tot++; if (a_dec !== 16'h0008) begin bad++; $display("FAIL held_c2 got=%h exp=0008", a_dec); end
        @(posedge clk); @(negedge clk);
        tot++; if (a_dec !== 16'h0000 || a_ready !== 1'b1) begin bad++; $display("FAIL held_gap got=%h ready=%b exp=0000 ready=1", a_dec, a_ready); end
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        tot++; if (a_dec !== 16'h0200) begin bad++; $display("FAIL held_next1 got=%h exp=0200", a_dec); end
        @(posedge clk); @(negedge clk);
        tot++; if (a_dec !== 16'h0200) begin bad++; $display("FAIL held_next2 got=%h exp=0200", a_dec); end
        @(posedge clk); @(negedge clk);
        tot++; if (a_dec !== 16'h0000) begin bad++; $display("FAIL held_end got=%h exp=0000", a_dec); end
    endtask

    task automatic test_clear_mid_hold();
        @(negedge clk); a_valid = 1'b1; a_sel = 4'd5;
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        tot++; if (a_dec !== 16'h0020) begin bad++; $display("FAIL clr_pre got=%h exp=0020", a_dec); end
        #1 clear = 1'b1;
        #1;
        tot++; if (a_dec !== 16'h0000) begin bad++; $display("FAIL clr_dec got=%h exp=0000", a_dec); end
        tot++; if ({a_busy, a_dv, a_ready} !== 3'b001) begin bad++; $display("FAIL clr_flags got=%b exp=001", {a_busy, a_dv, a_ready}); end
        @(negedge clk); clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            tot++; if (a_dec !== 16'h0000 || a_busy !== 1'b0) begin bad++; $display("FAIL clr_after cyc=%0d got=%h busy=%b exp=0000 busy=0", i, a_dec, a_busy); end
        end
    endtask

`ifdef SELDEC_SWEEP_EN
    task automatic test_sweep();
        logic [7:0] exp;
        @(negedge clk); c_sweep = 1'b1; c_valid = 1'b1; c_sel = 3'd2;
        tot++; if (c_ready !== 1'b0) begin bad++; $display("FAIL sweep_ready_start got=%b exp=0", c_ready); end
        @(posedge clk); #1 c_sweep = 1'b0; c_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            exp = 8'd1 << (j / 2);
            @(negedge clk);
            tot++; if (c_dec !== exp) begin bad++; $display("FAIL sweep_walk j=%0d got=%h exp=%h", j, c_dec, exp); end
            tot++; if ({c_busy, c_done} !== 2'b10) begin bad++; $display("FAIL sweep_flags j=%0d got=%b exp=10", j, {c_busy, c_done}); end
            @(posedge clk);
        end
        @(negedge clk);
        tot++; if (c_dec !== 8'h00) begin bad++; $display("FAIL sweep_end got=%h exp=00", c_dec); end
        tot++; if ({c_busy, c_done} !== 2'b01) begin bad++; $display("FAIL sweep_done_pulse got=%b exp=01", {c_busy, c_done}); end
        @(posedge clk); @(negedge clk);
        tot++; if (c_done !== 1'b0) begin bad++; $display("FAIL sweep_done_clear got=%b exp=0", c_done); end
    endtask
`else
    task automatic test_sweep_disabled();
        @(negedge clk); c_sweep = 1'b1; c_valid = 1'b0;
        tot++; if (c_ready !== 1'b1) begin bad++; $display("FAIL nosweep_ready got=%b exp=1", c_ready); end
        @(posedge clk); #1 c_sweep = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tot++; if ({c_dec, c_busy, c_done} !== 10'd0) begin bad++; $display("FAIL nosweep cyc=%0d got=%h exp=0", i, {c_dec, c_busy, c_done}); end
            @(posedge clk);
        end
    endtask
`endif

    initial begin
        clear = 1'b1;
        a_valid = 1'b0; a_sel = '0; a_sweep = 1'b0;
        b_valid = 1'b0; b_sel = '0; b_sweep = 1'b0;
        c_valid = 1'b0; c_sel = '0; c_sweep = 1'b0;
        #12;
        test_reset_values();
        @(negedge clk); clear = 1'b0;
        test_single();
        test_exhaustive();
        test_held();
        test_clear_mid_hold();
`ifdef SELDEC_SWEEP_EN
        test_sweep();
`else
        test_sweep_disabled();
`endif
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
